// File: rtl/exposure_field_scheduler_pkg.sv
// Shared definitions for the step-and-scan exposure field scheduler.
// Holds the FSM state encoding and the fault code constants.
// No logic; imported by the scheduler top.
package exposure_field_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SCAN   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_SAFETY   = 2'b01;
  localparam logic [1:0] FLT_SCAN_TMO = 2'b10;
  localparam logic [1:0] FLT_STEP_TMO = 2'b11;

endpackage

// File: rtl/exposure_field_scheduler_field_stepper.sv
// Serpentine field walker: tracks target column/row, scan direction and last-field flag.
// Latency: init/advance take effect on the next clock; last_o is combinational from state.
// No backpressure; advances only when the scheduler pulses advance_i.
module exposure_field_scheduler_field_stepper #(
  parameter int COLS  = 4,
  parameter int ROWS  = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] col_o,
  output logic [IDX_W-1:0] row_o,
  output logic             dir_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] COL_MAX  = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ROW_MAX  = IDX_W'(ROWS - 1);
  // With an odd row count the walk ends on the right edge, otherwise on the left.
  localparam logic [IDX_W-1:0] LAST_COL = (ROWS % 2 == 1) ? COL_MAX : '0;

  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic             dir_q, dir_d;

  // Next position: even rows run left-to-right, odd rows right-to-left, row steps at the edge.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    dir_d = dir_q;
    if (init_i) begin
      col_d = '0;
      row_d = '0;
      dir_d = 1'b0;
    end else if (advance_i) begin
      dir_d = ~dir_q;
      if (!row_q[0]) begin
        if (col_q == COL_MAX) row_d = row_q + 1'b1;
        else                  col_d = col_q + 1'b1;
      end else begin
        if (col_q == '0) row_d = row_q + 1'b1;
        else             col_d = col_q - 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      dir_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      dir_q <= dir_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign dir_o  = dir_q;
  assign last_o = (row_q == ROW_MAX) && (col_q == LAST_COL);

endmodule

// File: rtl/exposure_field_scheduler.sv
// Step-and-scan scheduler: walks the field grid doing step -> settle -> scan per field.
// Latency: go pulses one cycle after state entry decision; source_on reacts combinationally to safety.
// Stage handshakes are waited on with TMO-cycle timeouts; expose_req low aborts to IDLE.
module exposure_field_scheduler
  import exposure_field_scheduler_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int ROWS   = 3,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 8,
  parameter int TMO    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             expose_req,
  input  logic             safety_sensor,
  input  logic             ws_move_done,
  input  logic             ws_scan_done,
  input  logic             rs_scan_done,
  output logic             ws_step_go,
  output logic [IDX_W-1:0] step_col,
  output logic [IDX_W-1:0] step_row,
  output logic             ws_scan_go,
  output logic             rs_scan_go,
  output logic             scan_dir,
  output logic             source_on,
  output logic [CNT_W-1:0] field_count,
  output logic             expose_done,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_W = $clog2(TMO + 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TMO - 1);

  state_e           state_q;
  logic [SET_W-1:0] settle_q;
  logic [TMR_W-1:0] tmr_q;
  logic             ws_done_q, rs_done_q;
  logic             ws_step_go_q, ws_scan_go_q, rs_scan_go_q;
  logic [CNT_W-1:0] field_count_q;
  logic             expose_done_q, fault_q;
  logic [1:0]       fault_code_q;

  logic stp_init, stp_adv, stp_last;
  logic step_tmo, scan_tmo, ws_got, rs_got;

  // Stepper control and timeout/done decode for the current cycle.
  always_comb begin
    stp_init = (state_q == ST_IDLE) && expose_req;
    stp_adv  = (state_q == ST_NEXT) && expose_req && !safety_sensor && !stp_last;
    step_tmo = (state_q == ST_STEP) && (tmr_q == TMO_LAST);
    scan_tmo = (state_q == ST_SCAN) && (tmr_q == TMO_LAST);
    ws_got   = ws_done_q | ws_scan_done;
    rs_got   = rs_done_q | rs_scan_done;
  end

  exposure_field_scheduler_field_stepper #(
    .COLS (COLS),
    .ROWS (ROWS),
    .IDX_W(IDX_W)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .init_i   (stp_init),
    .advance_i(stp_adv),
    .col_o    (step_col),
    .row_o    (step_row),
    .dir_o    (scan_dir),
    .last_o   (stp_last)
  );

  // Main sequencer: priority safety > timeout > request drop > stage done in the active states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      settle_q      <= '0;
      tmr_q         <= '0;
      ws_done_q     <= 1'b0;
      rs_done_q     <= 1'b0;
      ws_step_go_q  <= 1'b0;
      ws_scan_go_q  <= 1'b0;
      rs_scan_go_q  <= 1'b0;
      field_count_q <= '0;
      expose_done_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FLT_NONE;
    end else begin
      ws_step_go_q <= 1'b0;
      ws_scan_go_q <= 1'b0;
      rs_scan_go_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (expose_req) begin
            state_q       <= ST_STEP;
            ws_step_go_q  <= 1'b1;
            tmr_q         <= '0;
            field_count_q <= '0;
          end
        end
        ST_DONE: begin
          if (!expose_req) begin
            state_q       <= ST_IDLE;
            expose_done_q <= 1'b0;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          if (safety_sensor) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FLT_SAFETY;
          end else if (step_tmo) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FLT_STEP_TMO;
          end else if (scan_tmo) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= FLT_SCAN_TMO;
          end else if (!expose_req) begin
            state_q       <= ST_IDLE;
            field_count_q <= '0;
          end else begin
            case (state_q)
              ST_STEP: begin
                tmr_q <= tmr_q + 1'b1;
                if (ws_move_done) begin
                  state_q  <= ST_SETTLE;
                  settle_q <= SETTLE_INIT;
                end
              end
              ST_SETTLE: begin
                if (settle_q == '0) begin
                  state_q      <= ST_SCAN;
                  ws_scan_go_q <= 1'b1;
                  rs_scan_go_q <= 1'b1;
                  tmr_q        <= '0;
                  ws_done_q    <= 1'b0;
                  rs_done_q    <= 1'b0;
                end else begin
                  settle_q <= settle_q - 1'b1;
                end
              end
              ST_SCAN: begin
                tmr_q     <= tmr_q + 1'b1;
                ws_done_q <= ws_got;
                rs_done_q <= rs_got;
                if (ws_got && rs_got) state_q <= ST_NEXT;
              end
              ST_NEXT: begin
                field_count_q <= field_count_q + 1'b1;
                if (stp_last) begin
                  state_q       <= ST_DONE;
                  expose_done_q <= 1'b1;
                end else begin
                  state_q      <= ST_STEP;
                  ws_step_go_q <= 1'b1;
                  tmr_q        <= '0;
                end
              end
              default: state_q <= state_q;
            endcase
          end
        end
      endcase
    end
  end

  assign ws_step_go  = ws_step_go_q;
  assign ws_scan_go  = ws_scan_go_q;
  assign rs_scan_go  = rs_scan_go_q;
  assign field_count = field_count_q;
  assign expose_done = expose_done_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  // The source must drop in the very cycle the interlock rises, so it is not registered.
  assign source_on   = (state_q == ST_SCAN) && !safety_sensor;

endmodule

// File: tb/tb_exposure_field_scheduler.sv
// Bench for the exposure field scheduler: randomized stage responder, queue scoreboard.
// Expected field order, gaps and fault codes come from a grid-arithmetic reference model.
// A second 1x1 instance exercises the degenerate single-field wafer.
module tb_exposure_field_scheduler;
  import exposure_field_scheduler_pkg::*;

  localparam int COLS = 4, ROWS = 3, IDX_W = 4, CNT_W = 8, SETTLE = 8, TMO = 255;
  localparam int NF = COLS * ROWS;

  typedef struct {int row; int col; int dir;} fld_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, expose_req, safety_sensor, ws_move_done, ws_scan_done, rs_scan_done;
  logic ws_step_go, ws_scan_go, rs_scan_go, scan_dir, source_on, expose_done, fault;
  logic [IDX_W-1:0] step_col, step_row;
  logic [CNT_W-1:0] field_count;
  logic [1:0] fault_code;

  logic req1, safe1, tie_hi;
  logic step_go1, scan_go1, rs_go1, dir1, src1, done1, fault1;
  logic [IDX_W-1:0] col1, row1;
  logic [CNT_W-1:0] cnt1;
  logic [1:0] code1;

  exposure_field_scheduler #(.COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W), .CNT_W(CNT_W),
                             .SETTLE(SETTLE), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .expose_req(expose_req), .safety_sensor(safety_sensor),
    .ws_move_done(ws_move_done), .ws_scan_done(ws_scan_done), .rs_scan_done(rs_scan_done),
    .ws_step_go(ws_step_go), .step_col(step_col), .step_row(step_row),
    .ws_scan_go(ws_scan_go), .rs_scan_go(rs_scan_go), .scan_dir(scan_dir),
    .source_on(source_on), .field_count(field_count), .expose_done(expose_done),
    .fault(fault), .fault_code(fault_code));

  exposure_field_scheduler #(.COLS(1), .ROWS(1), .IDX_W(IDX_W), .CNT_W(CNT_W),
                             .SETTLE(SETTLE), .TMO(TMO)) dut1 (
    .clk(clk), .reset(reset), .expose_req(req1), .safety_sensor(safe1),
    .ws_move_done(tie_hi), .ws_scan_done(tie_hi), .rs_scan_done(tie_hi),
    .ws_step_go(step_go1), .step_col(col1), .step_row(row1),
    .ws_scan_go(scan_go1), .rs_scan_go(rs_go1), .scan_dir(dir1),
    .source_on(src1), .field_count(cnt1), .expose_done(done1),
    .fault(fault1), .fault_code(code1));

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fld_t q_fld[$];
  int   q_ss[$], q_gap[$], q_done[$], q_flt[$];
  bit   have_scan = 0;
  int   fix_mv = -1, fix_ws = -1, fix_rs = -1;
  bit   hold_move = 0, hold_rs = 0, noise_en = 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: k-th field of a serpentine walk, direction alternates per field.
  function automatic fld_t fld_at(input int k);
    fld_t f;
    int c;
    f.row = k / COLS;
    c     = k % COLS;
    f.col = (f.row % 2 == 0) ? c : COLS - 1 - c;
    f.dir = k % 2;
    return f;
  endfunction

  task automatic flush();
    q_fld.delete(); q_ss.delete(); q_gap.delete(); q_done.delete(); q_flt.delete();
    have_scan = 0;
  endtask

  // Stage responder: answers go pulses after chosen delays, injects stray done pulses in SETTLE.
  initial begin
    int mv_cnt, ws_cnt, rs_cnt, sp_cnt, d, a, b;
    mv_cnt = -1; ws_cnt = -1; rs_cnt = -1; sp_cnt = -1;
    ws_move_done = 0; ws_scan_done = 0; rs_scan_done = 0;
    forever begin
      @(negedge clk);
      ws_move_done = 0; ws_scan_done = 0; rs_scan_done = 0;
      if (reset) begin
        mv_cnt = -1; ws_cnt = -1; rs_cnt = -1; sp_cnt = -1;
      end else begin
        if (ws_step_go && !hold_move) begin
          d = (fix_mv >= 0) ? fix_mv : int'($urandom_range(0, 4));
          mv_cnt = d;
          q_ss.push_back(d + 1 + SETTLE);
        end
        if (ws_scan_go) begin
          a = (fix_ws >= 0) ? fix_ws : int'($urandom_range(0, 6));
          b = (fix_rs >= 0) ? fix_rs : int'($urandom_range(0, 6));
          ws_cnt = a;
          if (!hold_rs) begin
            rs_cnt = b;
            q_gap.push_back(((a > b) ? a : b) + 2);
          end
        end
        if (mv_cnt == 0) begin ws_move_done = 1; mv_cnt = -1; if (noise_en) sp_cnt = 2; end
        else if (mv_cnt > 0) mv_cnt--;
        if (sp_cnt == 0) begin ws_scan_done = 1; rs_scan_done = 1; sp_cnt = -1; end
        else if (sp_cnt > 0) sp_cnt--;
        if (ws_cnt == 0) begin ws_scan_done = 1; ws_cnt = -1; end
        else if (ws_cnt > 0) ws_cnt--;
        if (rs_cnt == 0) begin rs_scan_done = 1; rs_cnt = -1; end
        else if (rs_cnt > 0) rs_cnt--;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    bit pd, pf;
    int step_t, scan_t, eg;
    logic [IDX_W-1:0] sc, sr;
    fld_t e;
    pd = 0; pf = 0; step_t = 0; scan_t = 0; sc = '0; sr = '0;
    forever begin
      @(posedge clk); #1;
      if (ws_step_go) begin
        if (q_fld.size() > 0) e = q_fld.pop_front();
        else begin e.row = -1; e.col = -1; e.dir = -1; end
        check("step_row", step_row, e.row);
        check("step_col", step_col, e.col);
        check("scan_dir", scan_dir, e.dir);
        if (have_scan) begin
          eg = (q_gap.size() > 0) ? q_gap.pop_front() : -1;
          check("scan_to_step_gap", cyc - scan_t, eg);
          have_scan = 0;
        end
        step_t = cyc; sc = step_col; sr = step_row;
      end
      if (ws_scan_go || rs_scan_go) begin
        check("scan_go_pair", rs_scan_go, ws_scan_go);
        check("coords_stable", {step_row, step_col}, {sr, sc});
        eg = (q_ss.size() > 0) ? q_ss.pop_front() : -1;
        check("step_to_scan_gap", cyc - step_t, eg);
        have_scan = 1; scan_t = cyc;
      end
      if (expose_done && !pd) begin
        eg = (q_done.size() > 0) ? q_done.pop_front() : -1;
        check("done_field_count", field_count, eg);
        if (have_scan) begin
          eg = (q_gap.size() > 0) ? q_gap.pop_front() : -1;
          check("scan_to_done_gap", cyc - scan_t, eg);
          have_scan = 0;
        end
      end
      if (fault && !pf) begin
        eg = (q_flt.size() > 0) ? q_flt.pop_front() : -1;
        check("fault_code", fault_code, eg);
      end
      pd = expose_done; pf = fault;
    end
  end

  task automatic wait_event(input bit scan, input int count, output bit ok);
    int seen, n;
    seen = 0; n = 0;
    while (seen < count && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (scan ? ws_scan_go : ws_step_go) seen++;
    end
    ok = (seen == count);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    flush();
  endtask

  task automatic run_wafer();
    int n;
    flush();
    for (int k = 0; k < NF; k++) q_fld.push_back(fld_at(k));
    q_done.push_back(NF);
    @(negedge clk); expose_req = 1;
    n = 0;
    while (!expose_done && n < 4000) begin @(posedge clk); #1; n++; end
    check("done_reached", expose_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", expose_done, 1);
    check("count_hold", field_count, NF);
    check("fields_consumed", q_fld.size(), 0);
    @(negedge clk); expose_req = 0;
    @(posedge clk); #1;
    check("done_clear", expose_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, s1, c1;
    reset = 1; expose_req = 0; safety_sensor = 0;
    req1 = 0; safe1 = 0; tie_hi = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    check("reset_outputs", {ws_step_go, step_col, step_row, ws_scan_go, rs_scan_go, scan_dir,
                            source_on, field_count, expose_done, fault, fault_code}, 0);

    // Random-latency wafers with stray done pulses during settle.
    run_wafer();
    run_wafer();

    // Scan completions at SCAN+3 / SCAN+7.
    fix_mv = 0; fix_ws = 3; fix_rs = 7;
    run_wafer();

    // Safety interlock in the second SCAN cycle of field 5.
    fix_mv = -1; fix_ws = 6; fix_rs = 6;
    flush();
    for (int k = 0; k < 5; k++) q_fld.push_back(fld_at(k));
    q_flt.push_back(FLT_SAFETY);
    @(negedge clk); expose_req = 1;
    wait_event(1, 5, ok);
    check("wait_scan5", ok, 1);
    check("source_on_scan", source_on, 1);
    @(posedge clk); #1;
    safety_sensor = 1;
    #1;
    check("source_drop", source_on, 0);
    check("fault_not_yet", fault, 0);
    @(posedge clk); #1;
    check("fault_set", fault, 1);
    flush();
    for (int i = 0; i < 10; i++) begin @(negedge clk); expose_req = i[0]; end
    @(posedge clk); #1;
    check("fault_sticky", fault, 1);
    check("fault_code_sticky", fault_code, FLT_SAFETY);
    safety_sensor = 0; expose_req = 0;
    do_reset();
    @(posedge clk); #1;
    check("fault_cleared", {fault, fault_code}, 0);

    // Step timeout: move completion withheld.
    flush(); hold_move = 1;
    q_fld.push_back(fld_at(0)); q_flt.push_back(FLT_STEP_TMO);
    @(negedge clk); expose_req = 1;
    wait_event(0, 1, ok);
    check("wait_step_tmo", ok, 1);
    n = 0;
    while (!fault && n < TMO + 20) begin @(posedge clk); #1; n++; end
    check("step_tmo_cycles", n, TMO);
    expose_req = 0; hold_move = 0;
    do_reset();

    // Scan timeout: reticle completion withheld.
    hold_rs = 1;
    q_fld.push_back(fld_at(0)); q_flt.push_back(FLT_SCAN_TMO);
    @(negedge clk); expose_req = 1;
    wait_event(1, 1, ok);
    check("wait_scan_tmo", ok, 1);
    n = 0;
    while (!fault && n < TMO + 20) begin @(posedge clk); #1; n++; end
    check("scan_tmo_cycles", n, TMO);
    expose_req = 0; hold_rs = 0;
    do_reset();

    // Request dropped during SETTLE of the third field, then restarted.
    fix_mv = 0; fix_ws = -1; fix_rs = -1;
    for (int k = 0; k < NF; k++) q_fld.push_back(fld_at(k));
    @(negedge clk); expose_req = 1;
    wait_event(0, 3, ok);
    check("wait_step3", ok, 1);
    check("count_before_abort", field_count, 2);
    repeat (2) @(posedge clk);
    #1;
    expose_req = 0;
    @(posedge clk); #1;
    check("abort_count_cleared", field_count, 0);
    check("abort_no_done", expose_done, 0);
    check("abort_source_off", source_on, 0);
    repeat (3) @(posedge clk);
    run_wafer();

    // Reset asserted mid-SCAN.
    fix_ws = 6; fix_rs = 6;
    flush();
    q_fld.push_back(fld_at(0));
    @(negedge clk); expose_req = 1;
    wait_event(1, 1, ok);
    check("wait_scan_rst", ok, 1);
    reset = 1;
    @(posedge clk); #1;
    check("reset_mid_scan", {ws_step_go, step_col, step_row, ws_scan_go, rs_scan_go, scan_dir,
                             source_on, field_count, expose_done, fault, fault_code}, 0);
    expose_req = 0;
    @(negedge clk); reset = 0;
    flush();

    // Single-field wafer on the 1x1 instance.
    s1 = 0; c1 = 0;
    @(negedge clk); req1 = 1;
    n = 0;
    while (!done1 && n < 500) begin
      @(posedge clk); #1; n++;
      if (step_go1) begin
        s1++;
        check("one_step_pos", {row1, col1, dir1}, 0);
      end
      if (scan_go1) begin
        c1++;
        check("one_scan_pair", rs_go1, 1);
      end
    end
    check("one_done", done1, 1);
    check("one_count", cnt1, 1);
    check("one_steps", s1, 1);
    check("one_scans", c1, 1);
    check("one_no_fault", {fault1, code1, src1}, 0);
    @(negedge clk); req1 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
